// File: rtl/stack_pkg.sv
// Shared types and constants for the operand-stack sequencer.
// stk_req() gives, per opcode, the pops it needs and whether it pushes a result.
package stack_pkg;

  localparam int STK_W     = 8;
  localparam int STK_DEPTH = 32;

  typedef enum logic [2:0] {
    OP_PUSHI = 3'b000,
    OP_POP   = 3'b001,
    OP_ADD   = 3'b010,
    OP_SUB   = 3'b011,
    OP_AND   = 3'b100,
    OP_OR    = 3'b101,
    OP_NOT   = 3'b110,
    OP_RSVD  = 3'b111
  } stk_op_e;

  typedef enum logic [2:0] {
    S_IDLE, S_POP1, S_TOS1, S_POP2, S_TOS2, S_EXEC, S_PUSH, S_FIN
  } stk_state_e;

  typedef struct packed {
    logic       legal;
    logic [1:0] pops;
    logic       push;
  } stk_req_t;

  function automatic stk_req_t stk_req(input stk_op_e op);
    stk_req_t r;
    r.legal = 1'b1;
    r.pops  = 2'd2;
    r.push  = 1'b1;
    case (op)
      OP_PUSHI: r.pops = 2'd0;
      OP_POP:   begin r.pops = 2'd1; r.push = 1'b0; end
      OP_NOT:   r.pops = 2'd1;
      OP_RSVD:  begin r.legal = 1'b0; r.pops = 2'd0; r.push = 1'b0; end
      default:  ;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/stack_op_seq_alu.sv
// Combinational stack ALU: a is the deeper operand, b the former top.
// Any opcode without an arithmetic meaning passes b through.
module stack_alu
  import stack_pkg::*;
#(
  parameter int W = STK_W
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  stk_op_e      i_op,
  output logic [W-1:0] o_result,
  output logic         o_zero
);

  always_comb begin
    o_result = i_b;
    case (i_op)
      OP_ADD:  o_result = i_a + i_b;
      OP_SUB:  o_result = i_a - i_b;
      OP_AND:  o_result = i_a & i_b;
      OP_OR:   o_result = i_a | i_b;
      OP_NOT:  o_result = ~i_b;
      default: o_result = i_b;
    endcase
    o_zero = (o_result == '0);
  end

endmodule

// File: rtl/stack_op_seq.sv
// Expands one stack command into the pop/tos/push strobe sequence of the operand stack.
// States: IDLE accept | POP1,POP2 pop | TOS1,TOS2 read | EXEC capture | PUSH write | FIN done
module stack_op_seq
  import stack_pkg::*;
#(
  parameter int W     = STK_W,
  parameter int DEPTH = STK_DEPTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [2:0]   cmd_op,
  input  logic [W-1:0] cmd_imm,
  output logic         done,
  output logic         err,
  output logic [W-1:0] result,
  output logic         zero,
  output logic [5:0]   depth,
  output logic [W-1:0] stk_din,
  output logic         stk_push,
  output logic         stk_pop,
  output logic         stk_tos,
  input  logic [W-1:0] stk_dout
);

  stk_state_e   r_state, w_next;
  stk_op_e      r_op;
  logic [W-1:0] r_imm, r_a, r_b, r_result;
  logic         r_zero, r_err;
  logic [5:0]   r_depth;

  stk_req_t     w_req;
  logic         w_reject, w_binary, w_alu_zero;
  logic [W-1:0] w_alu, w_push_val;

  assign w_req    = stk_req(stk_op_e'(cmd_op));
  // Depth limits are judged at accept, so a rejected command never touches the stack.
  assign w_reject = !w_req.legal
                 || (r_depth < 6'(w_req.pops))
                 || (({1'b0, r_depth} + 7'(w_req.push)) > (7'(DEPTH) + 7'(w_req.pops)));
  assign w_binary = (r_op == OP_ADD) || (r_op == OP_SUB) || (r_op == OP_AND) || (r_op == OP_OR);
  assign w_push_val = (r_op == OP_PUSHI) ? r_imm : w_alu;

  stack_alu #(.W(W)) u_alu (
    .i_a      (r_a),
    .i_b      (r_b),
    .i_op     (r_op),
    .o_result (w_alu),
    .o_zero   (w_alu_zero)
  );

  always_comb begin
    w_next    = r_state;
    cmd_ready = 1'b0;
    stk_pop   = 1'b0;
    stk_tos   = 1'b0;
    stk_push  = 1'b0;
    stk_din   = '0;
    done      = 1'b0;
    err       = 1'b0;
    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) w_next = w_reject ? S_FIN : ((w_req.pops == 2'd0) ? S_PUSH : S_POP1);
      end
      S_POP1: begin stk_pop = 1'b1; w_next = S_TOS1; end
      S_TOS1: begin stk_tos = 1'b1; w_next = w_binary ? S_POP2 : S_EXEC; end
      S_POP2: begin stk_pop = 1'b1; w_next = S_TOS2; end
      S_TOS2: begin stk_tos = 1'b1; w_next = S_EXEC; end
      S_EXEC: w_next = (r_op == OP_POP) ? S_FIN : S_PUSH;
      S_PUSH: begin stk_push = 1'b1; stk_din = w_push_val; w_next = S_FIN; end
      S_FIN:  begin done = 1'b1; err = r_err; w_next = S_IDLE; end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_op     <= OP_PUSHI;
      r_imm    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_err    <= 1'b0;
      r_depth  <= '0;
    end else begin
      r_state <= w_next;
      if (cmd_ready && cmd_valid) begin
        r_op  <= stk_op_e'(cmd_op);
        r_imm <= cmd_imm;
        r_err <= w_reject;
      end
      // Stack data lands one cycle after each tos strobe: first read is b, second is a.
      if (r_state == S_POP2) r_b <= stk_dout;
      if (r_state == S_EXEC) begin
        if (w_binary) r_a <= stk_dout;
        else          r_b <= stk_dout;
      end
      if (r_state == S_EXEC && r_op == OP_POP) begin
        r_result <= stk_dout;
        r_zero   <= (stk_dout == '0);
      end
      if (r_state == S_PUSH && r_op != OP_PUSHI) begin
        r_result <= w_alu;
        r_zero   <= w_alu_zero;
      end
      if (stk_push)     r_depth <= r_depth + 6'd1;
      else if (stk_pop) r_depth <= r_depth - 6'd1;
    end
  end

  assign result = r_result;
  assign zero   = r_zero;
  assign depth  = r_depth;

endmodule

// File: tb/tb_stack_op_seq.sv
// Bench for stack_op_seq: behavioural stack array plus a queue-based reference of stack contents.
// Directed scenarios first, then randomized command streams.
module tb_stack_op_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_imm;
  logic       done, err, zero;
  logic [7:0] result, stk_din, stk_dout;
  logic [5:0] depth;
  logic       stk_push, stk_pop, stk_tos;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  stack_op_seq dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_imm(cmd_imm), .done(done), .err(err),
    .result(result), .zero(zero), .depth(depth), .stk_din(stk_din),
    .stk_push(stk_push), .stk_pop(stk_pop), .stk_tos(stk_tos), .stk_dout(stk_dout)
  );

  // Operand stack: pop drops the pointer, the following tos reads the slot just vacated.
  logic [7:0] mem [0:31];
  int         sp;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sp       <= 0;
      stk_dout <= 8'h00;
    end else if (stk_push && sp < 32) begin
      mem[sp] <= stk_din;
      sp      <= sp + 1;
    end else if (stk_pop && sp > 0) begin
      sp <= sp - 1;
    end else if (stk_tos && sp < 32) begin
      stk_dout <= mem[sp];
    end
  end

  logic [7:0] q[$];
  logic [7:0] exp_res;
  logic       exp_zero;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cmd_valid = 1'b0;
    q.delete();
    exp_res  = 8'h00;
    exp_zero = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Issue one command from a negedge; hold keeps cmd_valid high afterwards.
  // abort_at > 0 asserts reset at that cycle after accept instead of finishing.
  task automatic do_cmd(input logic [2:0] op, input logic [7:0] imm, input bit hold, input int abort_at);
    int         need, lat_exp, lat, k;
    bit         rej, multi, seen;
    logic [7:0] a, b, r, pushv, din_seen;
    logic [9:0] tr, tr_exp;
    need  = (op == 3'd0) ? 0 : ((op == 3'd1 || op == 3'd6) ? 1 : 2);
    rej   = (op == 3'd7) || (q.size() < need) || (op == 3'd0 && q.size() >= 32);
    pushv = 8'h00;
    a = 8'h00; b = 8'h00; r = 8'h00;
    if (rej) begin
      lat_exp = 1; tr_exp = 10'b0;
    end else begin
      case (op)
        3'd0: begin q.push_back(imm); pushv = imm; lat_exp = 2; tr_exp = 10'b11; end
        3'd1: begin b = q.pop_back(); exp_res = b; lat_exp = 4; tr_exp = 10'b01_10; end
        3'd6: begin
          b = q.pop_back(); r = ~b; q.push_back(r); exp_res = r; pushv = r;
          lat_exp = 5; tr_exp = 10'b01_10_11;
        end
        default: begin
          b = q.pop_back(); a = q.pop_back();
          case (op)
            3'd2:    r = a + b;
            3'd3:    r = a - b;
            3'd4:    r = a & b;
            default: r = a | b;
          endcase
          q.push_back(r); exp_res = r; pushv = r;
          lat_exp = 7; tr_exp = 10'b01_10_01_10_11;
        end
      endcase
      if (op != 3'd0) exp_zero = (exp_res == 8'h00);
    end

    cmd_valid = 1'b1; cmd_op = op; cmd_imm = imm;
    k = 0;
    while (!cmd_ready && k < 20) begin @(negedge clk); k++; end
    if (!cmd_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      return;
    end
    @(posedge clk);
    tr = 10'b0; lat = 0; multi = 1'b0; din_seen = 8'h00;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (!hold) cmd_valid = 1'b0;
      if (c == abort_at) begin
        chk("abort_in_tos2", stk_tos, 1);
        rst = 1'b1;
        #1;
        chk("abort_done", done, 0);
        chk("abort_err", err, 0);
        chk("abort_result", result, 0);
        chk("abort_zero", zero, 0);
        chk("abort_depth", depth, 0);
        chk("abort_strobes", {stk_pop, stk_tos, stk_push, stk_din}, 0);
        chk("abort_ready", cmd_ready, 1);
        q.delete(); exp_res = 8'h00; exp_zero = 1'b0;
        cmd_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (8) begin @(negedge clk); if (done) seen = 1'b1; end
        chk("abort_no_done", seen, 0);
        return;
      end
      if ((int'(stk_pop) + int'(stk_tos) + int'(stk_push)) > 1) multi = 1'b1;
      if (stk_pop)  tr = (tr << 2) | 10'd1;
      if (stk_tos)  tr = (tr << 2) | 10'd2;
      if (stk_push) begin tr = (tr << 2) | 10'd3; din_seen = stk_din; end
      if (done) begin lat = c; break; end
    end
    chk("latency", lat, lat_exp);
    chk("strobe_seq", tr, tr_exp);
    chk("strobe_onehot", multi, 0);
    chk("err", err, rej);
    chk("result", result, exp_res);
    chk("zero", zero, exp_zero);
    chk("depth", depth, q.size());
    if (!rej && op != 3'd1) chk("stk_din", din_seen, pushv);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int rr;
    cmd_valid = 1'b0; cmd_op = 3'd0; cmd_imm = 8'h00; rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_result", result, 0);
    chk("rst_zero", zero, 0);
    chk("rst_depth", depth, 0);
    chk("rst_strobes", {stk_pop, stk_tos, stk_push, stk_din}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", cmd_ready, 1);

    do_cmd(3'd0, 8'h05, 0, 0);
    do_cmd(3'd0, 8'h03, 0, 0);
    do_cmd(3'd3, 8'h00, 0, 0);

    do_reset();
    do_cmd(3'd0, 8'hFF, 0, 0);
    do_cmd(3'd0, 8'h01, 0, 0);
    do_cmd(3'd2, 8'h00, 0, 0);
    do_cmd(3'd1, 8'h00, 0, 0);

    do_reset();
    do_cmd(3'd1, 8'h00, 0, 0);

    do_reset();
    for (int i = 0; i < 31; i++) do_cmd(3'd0, 8'(i * 7 + 1), 0, 0);
    do_cmd(3'd0, 8'h0F, 0, 0);
    do_cmd(3'd0, 8'h55, 0, 0);
    do_cmd(3'd6, 8'h00, 0, 0);

    do_cmd(3'd7, 8'h00, 0, 0);
    do_cmd(3'd4, 8'h00, 1, 0);
    do_cmd(3'd0, 8'h3C, 1, 0);
    do_cmd(3'd5, 8'h00, 1, 0);
    do_cmd(3'd1, 8'h00, 1, 0);
    cmd_valid = 1'b0;

    do_reset();
    do_cmd(3'd0, 8'h21, 0, 0);
    do_cmd(3'd0, 8'h12, 0, 0);
    do_cmd(3'd2, 8'h00, 0, 4);
    do_cmd(3'd0, 8'hA5, 0, 0);
    do_cmd(3'd1, 8'h00, 0, 0);

    do_reset();
    for (int i = 0; i < 400; i++) begin
      rr = $urandom_range(0, 10);
      if (rr <= 3) do_cmd(3'd0, 8'($urandom), 1'($urandom), 0);
      else if (rr == 10) do_cmd(3'd7, 8'($urandom), 1'($urandom), 0);
      else do_cmd(3'(rr - 3), 8'($urandom), 1'($urandom), 0);
    end
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/stack_op_seq.md
Name: stack_op_seq

Overview:
Multicycle sequencer that drives the 32x8 operand stack's push/pop/tos port on behalf of the CPU controller. It accepts one stack command per handshake and expands it into the exact pop/tos/push cycle sequence the stack needs. It computes 8-bit ALU results for stack arithmetic and tracks stack depth so that underflow and overflow are caught before the stack is touched. It sits between the main controller FSM and the stack.

Parameters:
DEPTH, 32, stack entry count; must match the stack instance
W, 8, data width

Ports:
clk  input  1  clock
rst  input  1  reset
cmd_valid  input  1  command request
cmd_ready  output  1  sequencer idle and able to accept
cmd_op  input  3  opcode (see Behaviour)
cmd_imm  input  W  immediate for PUSHI
done  output  1  one-cycle pulse when a command completes
err  output  1  valid with done; command rejected
result  output  W  popped value (POP) or computed value (ALU ops), held until next done
zero  output  1  result == 0, valid with result
depth  output  6  current element count, 0..DEPTH
stk_din  output  W  stack write data
stk_push  output  1  stack push strobe
stk_pop  output  1  stack pop strobe
stk_tos  output  1  stack read-top strobe
stk_dout  input  W  stack registered read data

Behaviour:
- Reset rst, asynchronous, active-high; clock clk. Reset returns state to IDLE and clears all outputs and registers: depth=0, result=0, done=0, err=0, and all stk_* strobes=0. An asserted reset mid-command aborts the command with no done. The stack shares rst, so depth=0 stays consistent with it.
- Stack contract:
  - Each strobe is a one-cycle pulse. At most one of stk_push, stk_pop and stk_tos is high in any cycle.
  - Reading and removing the top element takes two cycles: a stk_pop cycle, whose data is ignored, followed by a stk_tos cycle.
  - stk_dout is valid in the cycle after the stk_tos cycle. The sequencer captures it on that cycle's closing edge.
- Opcodes:
  - 000 PUSHI: needs depth<DEPTH; net depth +1.
  - 001 POP: needs depth>=1; net -1; result = popped value.
  - 010 ADD: needs depth>=2; net -1.
  - 011 SUB: needs depth>=2; net -1.
  - 100 AND: needs depth>=2; net -1.
  - 101 OR: needs depth>=2; net -1.
  - 110 NOT: needs depth>=1; net 0.
  - 111: reserved.
- Binary operand order: b is the first value popped (the top); a is the second. ADD = a+b, SUB = a-b, AND = a&b, OR = a|b. All results are mod 2^W; no carry out. NOT = ~b.
- cmd_ready = (state==IDLE). A command is accepted on a clock edge where cmd_valid and cmd_ready are both high, and cmd_op/cmd_imm are latched on that edge.
- FSM states: IDLE, POP1, TOS1, POP2, TOS2, EXEC, PUSH, FIN.
  - Binary: IDLE -> POP1 -> TOS1 -> POP2 (capture b at end) -> TOS2 -> EXEC (capture a, compute) -> PUSH -> FIN.
  - NOT: IDLE -> POP1 -> TOS1 -> EXEC (capture b, compute) -> PUSH -> FIN.
  - POP: IDLE -> POP1 -> TOS1 -> EXEC (capture into result) -> FIN.
  - PUSHI: IDLE -> PUSH (stk_din = imm) -> FIN.
- In PUSH, stk_din is driven with the value to push and stk_push=1.
- FIN lasts one cycle: done=1 (pulse), result and zero are updated, and the next state is IDLE. The pulse count per command type is specified as: done rises 2 cycles after accept for PUSHI, 4 for POP and 5 for NOT. For binary ops, done rises 7 cycles after the accept edge.
- Rejection: an illegal opcode, underflow or overflow detected at accept goes IDLE -> FIN with err=1. In that path there are no stack strobes, depth is unchanged, and result is unchanged.
- depth updates by net amount on the cycle of each stk_push (+1) and stk_pop (-1). Between pops it can transiently drop below the final value.
- cmd_valid while busy is ignored and must be held by the master.

Decomposition:
- Package stack_pkg: opcode enum stk_op_e, FSM state enum, W/DEPTH constants, and an operand-count lookup function (needs/net depth per opcode).
- Sub-module stack_alu (combinational a, b, op -> result, zero) is natural and separately testable.

Test Plan:
- Reset, PUSHI 0x05, PUSHI 0x03, SUB -> done after 7 cycles, result=0x02, zero=0, depth=1. Strobe order is pop, tos, pop, tos, push, with stk_din=0x02.
- PUSHI 0xFF, PUSHI 0x01, ADD -> result=0x00, zero=1, depth=1. Then POP -> result=0x00, depth=0.
- Reset then POP -> err=1 with done 1 cycle after accept; no stk_* strobes; depth=0.
- 32 PUSHI -> depth=32; 33rd PUSHI -> err=1, no stk_push. Then NOT on top value 0x0F -> 0xF0, depth stays 32.
- cmd_op=111 -> err=1, no strobes. Back-to-back commands with cmd_valid held high are accepted on each IDLE cycle with no lost command.
- Assert rst during TOS2 of an ADD -> all outputs 0 and depth=0 immediately; no done; next PUSHI works.
